// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage
//  Description : Registered output stage behind the 32-bit CLA ALU. Captures
//                the ALU result with its op tag, derives zero, overflow
//                exception, write-enable and branch-taken flags, and hands
//                them to the MEM/WB side through a valid/ready handshake
//                backed by a 2-entry skid buffer. Also keeps a saturating
//                count of accepted overflow-exception entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    // upstream (ALU) side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     alu_r,
    input  logic             alu_v,
    input  logic             alu_cout,
    input  logic [2:0]       alu_op,
    input  logic             in_trap,
    input  logic [1:0]       in_br,
    input  logic [4:0]       in_dest,
    // downstream (MEM/WB) side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_r,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_ovf_exc,
    output logic             out_we,
    output logic             out_br_taken,
    output logic [4:0]       out_dest,
    // overflow-exception statistics
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Entry layout: {dest[4:0], br_taken, we, ovf_exc, zero, cout, r[W-1:0]}
    localparam int c_ENT_W     = W + 10;
    localparam int c_R_LSB     = 0;
    localparam int c_COUT_BIT  = W;
    localparam int c_ZERO_BIT  = W + 1;
    localparam int c_EXC_BIT   = W + 2;
    localparam int c_WE_BIT    = W + 3;
    localparam int c_BR_BIT    = W + 4;
    localparam int c_DEST_LSB  = W + 5;

    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;

    localparam logic [1:0] c_BR_NONE = 2'b00;
    localparam logic [1:0] c_BR_BEQ  = 2'b01;
    localparam logic [1:0] c_BR_BNE  = 2'b10;
    localparam logic [1:0] c_BR_RSVD = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Occupancy states: how many entries the stage currently holds
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [c_ENT_W-1:0] r_main;
    logic [c_ENT_W-1:0] r_skid;
    logic [CNT_W-1:0]   r_ovf_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_is_arith;
    logic               w_ovf_exc;
    logic               w_zero;
    logic               w_no_br;
    logic               w_we;
    logic               w_br_taken;
    logic [c_ENT_W-1:0] w_entry;

    logic [1:0]         w_state_nxt;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;

    // ------------------------------------------------------------------------
    // Handshake: both sides use the registered status flags
    // ------------------------------------------------------------------------
    assign w_push = in_valid  & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Flag derivation at capture time
    // ------------------------------------------------------------------------
    // Only trapping add/sub may raise an overflow exception; logical ops and
    // SLT never do, regardless of the ALU's V flag.
    assign w_is_arith = (alu_op == c_OP_ADD) | (alu_op == c_OP_SUB);
    assign w_ovf_exc  = in_trap & alu_v & w_is_arith;
    assign w_zero     = (alu_r == {W{1'b0}});

    // Reserved branch encoding behaves as "no branch", so it still writes.
    assign w_no_br    = (in_br == c_BR_NONE) | (in_br == c_BR_RSVD);
    assign w_we       = (in_dest != 5'd0) & ~w_ovf_exc & w_no_br;
    assign w_br_taken = ((in_br == c_BR_BEQ) &  w_zero) |
                        ((in_br == c_BR_BNE) & ~w_zero);

    assign w_entry = {in_dest, w_br_taken, w_we, w_ovf_exc, w_zero, alu_cout, alu_r};

    // ------------------------------------------------------------------------
    // Occupancy next-state and buffer load selection
    // ------------------------------------------------------------------------
    // Decide next occupancy and which register captures what this cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    // Old entry leaves while the new one takes its place.
                    w_load_main_in = 1'b1;
                end else if (w_push) begin
                    // Downstream stalled: park the new entry in the skid slot.
                    w_state_nxt = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a pop can move things.
                if (w_pop) begin
                    w_state_nxt      = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
        // Flush discards everything, including a push arriving this cycle.
        if (flush) begin
            w_state_nxt      = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // Occupancy state plus its registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_TWO);
            r_out_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    // Main and skid entry registers; main drives the outputs directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main <= {c_ENT_W{1'b0}};
            r_skid <= {c_ENT_W{1'b0}};
        end else begin
            if (w_load_main_in) begin
                r_main <= w_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    // Saturating count of accepted overflow exceptions; clear has priority
    // and a push swallowed by flush is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt <= {CNT_W{1'b0}};
        end else if (ovf_clr) begin
            r_ovf_cnt <= {CNT_W{1'b0}};
        end else if (w_push && !flush && w_ovf_exc && (r_ovf_cnt != c_CNT_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_r        = r_main[c_R_LSB +: W];
    assign out_cout     = r_main[c_COUT_BIT];
    assign out_zero     = r_main[c_ZERO_BIT];
    assign out_ovf_exc  = r_main[c_EXC_BIT];
    assign out_we       = r_main[c_WE_BIT];
    assign out_br_taken = r_main[c_BR_BIT];
    assign out_dest     = r_main[c_DEST_LSB +: 5];
    assign ovf_count    = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Self-checking bench for alu_result_stage. A queue-based
//                reference model (at most two entries) tracks what the stage
//                must present; directed scenarios and a randomized run are
//                compared against it and against hand-derived constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int W     = 32;
    localparam int CNT_W = 8;
    localparam int c_CNT_MAX = 255;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  alu_r;
    logic          alu_v;
    logic          alu_cout;
    logic [2:0]    alu_op;
    logic          in_trap;
    logic [1:0]    in_br;
    logic [4:0]    in_dest;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_r;
    logic          out_cout;
    logic          out_zero;
    logic          out_ovf_exc;
    logic          out_we;
    logic          out_br_taken;
    logic [4:0]    out_dest;
    logic [CNT_W-1:0] ovf_count;
    logic          ovf_clr;

    alu_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_r        (alu_r),
        .alu_v        (alu_v),
        .alu_cout     (alu_cout),
        .alu_op       (alu_op),
        .in_trap      (in_trap),
        .in_br        (in_br),
        .in_dest      (in_dest),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_r        (out_r),
        .out_cout     (out_cout),
        .out_zero     (out_zero),
        .out_ovf_exc  (out_ovf_exc),
        .out_we       (out_we),
        .out_br_taken (out_br_taken),
        .out_dest     (out_dest),
        .ovf_count    (ovf_count),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        cout;
        logic        zero;
        logic        exc;
        logic        we;
        logic        br;
        logic [4:0]  dest;
    } ent_t;

    ent_t mq[$];
    int   m_cnt;
    int   n_checks;
    int   n_fail;

    // Expected entry built straight from the documented flag rules.
    function automatic ent_t make_entry();
        ent_t e;
        bit   arith;
        e.r    = alu_r;
        e.cout = alu_cout;
        e.zero = (alu_r == 0);
        arith  = (alu_op == 3'b010) || (alu_op == 3'b110);
        e.exc  = in_trap && alu_v && arith;
        case (in_br)
            2'b01:   e.br = e.zero;
            2'b10:   e.br = !e.zero;
            default: e.br = 1'b0;
        endcase
        e.we   = (in_dest != 0) && !e.exc && (in_br == 2'b00 || in_br == 2'b11);
        e.dest = in_dest;
        return e;
    endfunction

    // Advance the model by the transfer implied by current inputs, then
    // clock the DUT and settle just after the edge.
    task automatic step();
        ent_t e;
        bit   push;
        bit   pop;
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            e    = make_entry();
            push = in_valid && (mq.size() < 2);
            pop  = (mq.size() > 0) && out_ready;
            if (ovf_clr)
                m_cnt = 0;
            else if (push && !flush && e.exc && m_cnt < c_CNT_MAX)
                m_cnt = m_cnt + 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        alu_r    = '0;
        alu_v    = 1'b0;
        alu_cout = 1'b0;
        alu_op   = 3'b000;
        in_trap  = 1'b0;
        in_br    = 2'b00;
        in_dest  = 5'd0;
        out_ready = 1'b1;
        ovf_clr  = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] r, input logic v,
                          input logic trap, input logic [1:0] br, input logic [4:0] dest);
        in_valid = 1'b1;
        alu_op   = op;
        alu_r    = r;
        alu_v    = v;
        alu_cout = r[0];
        in_trap  = trap;
        in_br    = br;
        in_dest  = dest;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_checks++; if ({out_r, out_cout, out_zero, out_ovf_exc, out_we, out_br_taken, out_dest} !== '0) begin
            n_fail++; $display("FAIL reset_data: got r=%0h flags=%0b%0b%0b%0b%0b dest=%0d expected all 0",
                               out_r, out_cout, out_zero, out_ovf_exc, out_we, out_br_taken, out_dest); end
        n_checks++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_add();
        idle_inputs();
        set_op(3'b010, 32'h0000_0005, 1'b0, 1'b1, 2'b00, 5'd3);
        step();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b expected 1", out_valid); end
        n_checks++; if (out_r !== 32'h5) begin n_fail++; $display("FAIL add_r: got %0h expected 5", out_r); end
        n_checks++; if (out_we !== 1'b1 || out_zero !== 1'b0 || out_dest !== 5'd3) begin
            n_fail++; $display("FAIL add_flags: got we=%0b zero=%0b dest=%0d expected we=1 zero=0 dest=3", out_we, out_zero, out_dest); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        idle_inputs();
        set_op(3'b110, 32'h8000_0001, 1'b1, 1'b1, 2'b00, 5'd8);
        step();
        n_checks++; if (out_ovf_exc !== 1'b1 || out_we !== 1'b0) begin
            n_fail++; $display("FAIL sub_trap_flags: got exc=%0b we=%0b expected exc=1 we=0", out_ovf_exc, out_we); end
        n_checks++; if (ovf_count !== 8'd1) begin n_fail++; $display("FAIL sub_trap_count: got %0d expected 1", ovf_count); end
        in_trap = 1'b0;
        step();
        idle_inputs();
        n_checks++; if (out_ovf_exc !== 1'b0 || out_we !== 1'b1) begin
            n_fail++; $display("FAIL subu_flags: got exc=%0b we=%0b expected exc=0 we=1", out_ovf_exc, out_we); end
        n_checks++; if (ovf_count !== 8'd1) begin n_fail++; $display("FAIL subu_count: got %0d expected 1", ovf_count); end
        // Overflow on a logical op never traps.
        set_op(3'b001, 32'h1, 1'b1, 1'b1, 2'b00, 5'd4);
        step();
        idle_inputs();
        n_checks++; if (out_ovf_exc !== 1'b0 || ovf_count !== 8'd1) begin
            n_fail++; $display("FAIL or_no_trap: got exc=%0b count=%0d expected exc=0 count=1", out_ovf_exc, ovf_count); end
        step();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        out_ready = 1'b0;
        set_op(3'b000, 32'hAAAA_0001, 1'b0, 1'b0, 2'b00, 5'd1);
        step();
        set_op(3'b000, 32'hBBBB_0002, 1'b0, 1'b0, 2'b00, 5'd2);
        step();
        n_checks++; if (in_ready !== 1'b0 || out_r !== 32'hAAAA_0001) begin
            n_fail++; $display("FAIL skid_full: got ready=%0b r=%0h expected ready=0 r=aaaa0001", in_ready, out_r); end
        set_op(3'b000, 32'hCCCC_0003, 1'b0, 1'b0, 2'b00, 5'd3);
        step();
        n_checks++; if (out_r !== 32'hAAAA_0001 || out_dest !== 5'd1 || mq.size() != 2) begin
            n_fail++; $display("FAIL stall_hold: got r=%0h dest=%0d expected r=aaaa0001 dest=1", out_r, out_dest); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_r !== 32'hBBBB_0002 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain_b: got r=%0h ready=%0b expected r=bbbb0002 ready=1", out_r, in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (out_r !== 32'hCCCC_0003 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL drain_c: got r=%0h valid=%0b expected r=cccc0003 valid=1", out_r, out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %0b expected 0", out_valid); end
    endtask

    task automatic test_branch();
        idle_inputs();
        set_op(3'b110, 32'h0, 1'b0, 1'b0, 2'b01, 5'd7);
        step();
        n_checks++; if (out_br_taken !== 1'b1 || out_we !== 1'b0) begin
            n_fail++; $display("FAIL beq_zero: got taken=%0b we=%0b expected taken=1 we=0", out_br_taken, out_we); end
        set_op(3'b110, 32'h10, 1'b0, 1'b0, 2'b10, 5'd7);
        step();
        n_checks++; if (out_br_taken !== 1'b1 || out_we !== 1'b0) begin
            n_fail++; $display("FAIL bne_nonzero: got taken=%0b we=%0b expected taken=1 we=0", out_br_taken, out_we); end
        set_op(3'b110, 32'h0, 1'b0, 1'b0, 2'b10, 5'd7);
        step();
        n_checks++; if (out_br_taken !== 1'b0 || out_zero !== 1'b1) begin
            n_fail++; $display("FAIL bne_zero: got taken=%0b zero=%0b expected taken=0 zero=1", out_br_taken, out_zero); end
        set_op(3'b110, 32'h0, 1'b0, 1'b0, 2'b11, 5'd7);
        step();
        idle_inputs();
        n_checks++; if (out_br_taken !== 1'b0 || out_we !== 1'b1) begin
            n_fail++; $display("FAIL br_reserved: got taken=%0b we=%0b expected taken=0 we=1", out_br_taken, out_we); end
        step();
    endtask

    task automatic test_flush();
        idle_inputs();
        out_ready = 1'b0;
        set_op(3'b010, 32'h11, 1'b0, 1'b0, 2'b00, 5'd1);
        step();
        set_op(3'b010, 32'h22, 1'b0, 1'b0, 2'b00, 5'd2);
        step();
        set_op(3'b010, 32'h33, 1'b1, 1'b1, 2'b00, 5'd3);
        flush = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_two: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid, in_ready); end
        // A flushed overflow push does not count.
        set_op(3'b010, 32'h44, 1'b1, 1'b1, 2'b00, 5'd4);
        flush = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (ovf_count !== 8'd1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_count: got count=%0d valid=%0b expected count=1 valid=0", ovf_count, out_valid); end
        set_op(3'b000, 32'h55, 1'b0, 1'b0, 2'b00, 5'd5);
        step();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1 || out_r !== 32'h55) begin
            n_fail++; $display("FAIL after_flush: got valid=%0b r=%0h expected valid=1 r=55", out_valid, out_r); end
        step();
    endtask

    task automatic test_ovf_saturate();
        idle_inputs();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        for (int i = 0; i < c_CNT_MAX; i++) begin
            set_op(3'b010, 32'h7FFF_FFFF, 1'b1, 1'b1, 2'b00, 5'(i % 32));
            step();
        end
        n_checks++; if (ovf_count !== 8'd255) begin n_fail++; $display("FAIL count_reach_max: got %0d expected 255", ovf_count); end
        step();
        n_checks++; if (ovf_count !== 8'd255) begin n_fail++; $display("FAIL count_saturate: got %0d expected 255", ovf_count); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_checks++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL clr_beats_inc: got %0d expected 0", ovf_count); end
        step();
        out_ready = 1'b0;
        step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 8'd0 || out_r !== 32'h0 ||
                        out_ovf_exc !== 1'b0 || out_dest !== 5'd0) begin
            n_fail++; $display("FAIL reset_midflight: got valid=%0b ready=%0b count=%0d r=%0h exc=%0b dest=%0d expected 0/1/0/0/0/0",
                               out_valid, in_ready, ovf_count, out_r, out_ovf_exc, out_dest); end
        step();
    endtask

    task automatic test_random();
        ent_t h;
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            alu_r     = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            alu_v     = $urandom_range(0, 1);
            alu_cout  = $urandom_range(0, 1);
            alu_op    = 3'($urandom_range(0, 7));
            in_trap   = $urandom_range(0, 1);
            in_br     = 2'($urandom_range(0, 3));
            in_dest   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            flush     = ($urandom_range(0, 40) == 0);
            ovf_clr   = ($urandom_range(0, 150) == 0);
            step();
            n_checks++;
            if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2) || ovf_count !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got valid=%0b ready=%0b count=%0d expected valid=%0b ready=%0b count=%0d",
                         i, out_valid, in_ready, ovf_count, mq.size() != 0, mq.size() < 2, m_cnt);
            end
            if (mq.size() != 0) begin
                h = mq[0];
                n_checks++;
                if ({out_r, out_cout, out_zero, out_ovf_exc, out_we, out_br_taken, out_dest} !== h) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got r=%0h c=%0b z=%0b e=%0b we=%0b br=%0b d=%0d expected r=%0h c=%0b z=%0b e=%0b we=%0b br=%0b d=%0d",
                             i, out_r, out_cout, out_zero, out_ovf_exc, out_we, out_br_taken, out_dest,
                             h.r, h.cout, h.zero, h.exc, h.we, h.br, h.dest);
                end
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cnt    = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_add();
        test_overflow();
        test_back_to_back();
        test_branch();
        test_flush();
        test_ovf_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
